// File: rtl/lane_scheduler_if.sv
// Control/status bundle between the game top level and the lane scheduler.
// master = game top level side, slave = scheduler side.
interface lane_scheduler_if #(
    parameter int LANES = 8
);
    logic             start;
    logic             pause;
    logic             collide;
    logic             level_up;
    logic [LANES-1:0] shift_en;
    logic [LANES-1:0] dir;
    logic [2:0]       level;
    logic [1:0]       state;

    modport master (
        output start, pause, collide, level_up,
        input  shift_en, dir, level, state
    );

    modport slave (
        input  start, pause, collide, level_up,
        output shift_en, dir, level, state
    );
endinterface

// File: rtl/lane_scheduler.sv
// Lane timing controller: game-flow FSM, base-tick prescaler, per-lane shift strobes.
// Optional macro SCHED_STAGGER_EN phase-offsets the lane counters on game start.
module lane_scheduler #(
    parameter int                   LANES     = 8,
    parameter int                   TICK_DIV  = 12500000,
    parameter logic [4*LANES-1:0]   LANE_BASE = 32'h25374638,
    parameter logic [LANES-1:0]     DIR_MASK  = 8'b01010101
) (
    input  logic              clk,
    input  logic              reset,
    lane_scheduler_if.slave   bus
);

    localparam int PCW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10,
        S_HALT   = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [PCW-1:0]   r_pc;
    logic [3:0]       r_cnt [LANES];
    logic [LANES-1:0] r_shift_en;
    logic [2:0]       r_level;

    logic             w_tick;
    logic             w_stay_run;
    logic             w_advance;
    logic             w_fire;
    logic             w_launch;
    logic [3:0]       w_per  [LANES];
    logic [3:0]       w_init [LANES];
    logic [LANES-1:0] w_hit;

    // Lane period shortened by the level, never below one tick.
    function automatic logic [3:0] lane_period(input logic [3:0] base, input logic [2:0] lvl);
        if (base > {1'b0, lvl}) begin
            return base - {1'b0, lvl};
        end else begin
            return 4'd1;
        end
    endfunction

    // Game-flow next-state decode; collide outranks pause.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next_state = S_RUN;
                else           w_next_state = S_IDLE;
            end
            S_RUN: begin
                if (bus.collide)    w_next_state = S_HALT;
                else if (bus.pause) w_next_state = S_PAUSED;
                else                w_next_state = S_RUN;
            end
            S_PAUSED: begin
                if (bus.collide)    w_next_state = S_HALT;
                else if (bus.pause) w_next_state = S_RUN;
                else                w_next_state = S_PAUSED;
            end
            S_HALT: begin
                if (bus.start) w_next_state = S_IDLE;
                else           w_next_state = S_HALT;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Leaving RUN on a tick edge freezes the prescaler and cancels that tick's strobes.
    assign w_tick     = (r_state == S_RUN) && (r_pc == PCW'(TICK_DIV - 1));
    assign w_stay_run = (r_state == S_RUN) && (w_next_state == S_RUN);
    assign w_advance  = (r_state == S_RUN) && (!w_tick || w_stay_run);
    assign w_fire     = w_tick && w_stay_run;
    assign w_launch   = (r_state == S_IDLE) && (w_next_state == S_RUN);

    // Per-lane period, terminal-count flag and start-of-game counter value.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_per[i] = lane_period(LANE_BASE[4*i +: 4], r_level);
            w_hit[i] = (r_cnt[i] == 4'd0);
`ifdef SCHED_STAGGER_EN
            w_init[i] = 4'(i % int'(w_per[i]));
`else
            w_init[i] = w_per[i] - 4'd1;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Prescaler, lane counters, strobes and difficulty level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_shift_en <= '0;
            r_level    <= 3'd0;
            for (int i = 0; i < LANES; i++) begin
                r_cnt[i] <= 4'd0;
            end
        end else begin
            r_shift_en <= w_fire ? w_hit : '0;

            if (w_launch) begin
                r_pc <= '0;
            end else if (w_advance) begin
                r_pc <= w_tick ? '0 : r_pc + PCW'(1);
            end

            for (int i = 0; i < LANES; i++) begin
                if (w_launch) begin
                    r_cnt[i] <= w_init[i];
                end else if (w_fire) begin
                    r_cnt[i] <= w_hit[i] ? (w_per[i] - 4'd1) : (r_cnt[i] - 4'd1);
                end
            end

            if ((r_state == S_HALT) && bus.start) begin
                r_level <= 3'd0;
            end else if (w_stay_run && bus.level_up && (r_level != 3'd7)) begin
                r_level <= r_level + 3'd1;
            end
        end
    end

    assign bus.shift_en = r_shift_en;
    assign bus.dir      = DIR_MASK;
    assign bus.level    = r_level;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler with TICK_DIV=4 and default lane table.
// Cycle 0 is the cycle in which start is held high; outputs are sampled 1 time unit after each edge.
module tb_lane_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    localparam logic [7:0] DIR_EXP = 8'b01010101;
    int per_tab [8] = '{8, 3, 6, 4, 7, 3, 5, 2};

    lane_scheduler_if #(.LANES(8)) bus ();

    lane_scheduler #(.LANES(8), .TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.collide  = 1'b0;
        bus.level_up = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic begin_run();
        bus.start = 1'b1;
        cyc = 0;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.level_up = 1'b1;
        step();
        step();
        checks++;
        if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state got %b expected 00", bus.state); end
        checks++;
        if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d expected 0", bus.level); end
        checks++;
        if (bus.shift_en !== 8'h00) begin errors++; $display("FAIL reset_shift got %b expected 00000000", bus.shift_en); end
        checks++;
        if (bus.dir !== DIR_EXP) begin errors++; $display("FAIL reset_dir got %b expected %b", bus.dir, DIR_EXP); end
        reset = 1'b0;
        idle_inputs();
        step();
        checks++;
        if (bus.state !== 2'b00) begin errors++; $display("FAIL idle_hold got %b expected 00", bus.state); end
    endtask

    task automatic test_start_strobes();
        logic [7:0] exp;
        do_reset();
        begin_run();
        checks++;
        if (bus.state !== 2'b01) begin errors++; $display("FAIL start_state got %b expected 01", bus.state); end
        for (int c = 1; c <= 80; c++) begin
            exp = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if ((c >= 1 + 4 * per_tab[i]) && (((c - 1) % (4 * per_tab[i])) == 0)) exp[i] = 1'b1;
            end
            checks++;
            if (bus.shift_en !== exp) begin
                errors++;
                $display("FAIL strobe cycle %0d got %b expected %b", c, bus.shift_en, exp);
            end
            step();
        end
        checks++;
        if (bus.dir !== DIR_EXP) begin errors++; $display("FAIL run_dir got %b expected %b", bus.dir, DIR_EXP); end
    endtask

    task automatic test_pause();
        logic [1:0] exp_state;
        logic       paused;
        do_reset();
        begin_run();
        for (int c = 1; c <= 40; c++) begin
            paused    = (c >= 7) && (c <= 26);
            exp_state = paused ? 2'b10 : 2'b01;
            checks++;
            if (bus.state !== exp_state) begin
                errors++;
                $display("FAIL pause_state cycle %0d got %b expected %b", c, bus.state, exp_state);
            end
            checks++;
            if (paused) begin
                if (bus.shift_en !== 8'h00) begin
                    errors++;
                    $display("FAIL pause_quiet cycle %0d got %b expected 00000000", c, bus.shift_en);
                end
            end else begin
                if (bus.shift_en[7] !== ((c == 29) || (c == 37))) begin
                    errors++;
                    $display("FAIL pause_lane7 cycle %0d got %b expected %b", c, bus.shift_en[7], (c == 29) || (c == 37));
                end
            end
            bus.pause = (c == 6) || (c == 26);
            step();
        end
        idle_inputs();
    endtask

    task automatic test_collide_pause();
        do_reset();
        begin_run();
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                checks++;
                if (bus.level !== 3'd1) begin errors++; $display("FAIL lvl_bump got %0d expected 1", bus.level); end
            end
            if (c == 9) begin
                checks++;
                if (bus.state !== 2'b11) begin errors++; $display("FAIL halt_state got %b expected 11", bus.state); end
                checks++;
                if (bus.shift_en !== 8'h00) begin errors++; $display("FAIL halt_strobe got %b expected 00000000", bus.shift_en); end
                checks++;
                if (bus.dir !== DIR_EXP) begin errors++; $display("FAIL halt_dir got %b expected %b", bus.dir, DIR_EXP); end
            end
            if (c == 11) begin
                checks++;
                if (bus.state !== 2'b11) begin errors++; $display("FAIL halt_frozen got %b expected 11", bus.state); end
                checks++;
                if (bus.level !== 3'd1) begin errors++; $display("FAIL halt_level got %0d expected 1", bus.level); end
            end
            if (c == 13) begin
                checks++;
                if (bus.state !== 2'b00) begin errors++; $display("FAIL halt_exit got %b expected 00", bus.state); end
                checks++;
                if (bus.level !== 3'd0) begin errors++; $display("FAIL level_clear got %0d expected 0", bus.level); end
            end
            bus.level_up = (c == 2);
            bus.collide  = (c == 8);
            bus.pause    = (c == 8) || (c == 10);
            bus.start    = (c == 12);
            step();
        end
        idle_inputs();
    endtask

    task automatic test_level();
        do_reset();
        begin_run();
        for (int c = 1; c <= 45; c++) begin
            if ((c == 8) || (c == 9)) begin
                checks++;
                if (bus.level !== 3'd7) begin errors++; $display("FAIL level_sat cycle %0d got %0d expected 7", c, bus.level); end
            end
            if ((c == 11) || (c == 13)) begin
                checks++;
                if (bus.shift_en[7] !== (c == 13)) begin
                    errors++;
                    $display("FAIL fast_lane7 cycle %0d got %b expected %b", c, bus.shift_en[7], c == 13);
                end
            end
            if ((c == 29) || (c == 33) || (c == 35) || (c == 37) || (c == 41)) begin
                checks++;
                if (bus.shift_en[0] !== (c != 29 && c != 35)) begin
                    errors++;
                    $display("FAIL fast_lane0 cycle %0d got %b expected %b", c, bus.shift_en[0], c != 29 && c != 35);
                end
            end
            bus.level_up = (c <= 8);
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_on_tick();
        do_reset();
        begin_run();
        for (int c = 1; c < 8; c++) step();
        reset = 1'b1;
        step();
        checks++;
        if (bus.shift_en !== 8'h00) begin errors++; $display("FAIL tick_reset_strobe got %b expected 00000000", bus.shift_en); end
        checks++;
        if (bus.state !== 2'b00) begin errors++; $display("FAIL tick_reset_state got %b expected 00", bus.state); end
        checks++;
        if (bus.dir !== DIR_EXP) begin errors++; $display("FAIL tick_reset_dir got %b expected %b", bus.dir, DIR_EXP); end
        reset = 1'b0;
        step();
        checks++;
        if (bus.shift_en !== 8'h00) begin errors++; $display("FAIL post_reset_strobe got %b expected 00000000", bus.shift_en); end
    endtask

`ifdef SCHED_STAGGER_EN
    task automatic test_stagger();
        do_reset();
        begin_run();
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (bus.shift_en[0] !== (c == 5)) begin
                errors++;
                $display("FAIL stagger_lane0 cycle %0d got %b expected %b", c, bus.shift_en[0], c == 5);
            end
            checks++;
            if (bus.shift_en[7] !== (c == 9)) begin
                errors++;
                $display("FAIL stagger_lane7 cycle %0d got %b expected %b", c, bus.shift_en[7], c == 9);
            end
            step();
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
`ifdef SCHED_STAGGER_EN
        test_stagger();
`else
        test_start_strobes();
        test_pause();
        test_level();
`endif
        test_collide_pause();
        test_reset_on_tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
